// File: rtl/rf_ctrl.sv
// Register-file command sequencer.
// Accepts one command at a time over a valid/ready handshake. It reads the two source operands,
// runs them through a small signed ALU and writes the result back through the register file's
// ports. It is the only driver of the file's address, enable and write-data pins. Every rf_*
// output is decoded from the FSM state and registered command fields, so no cmd_* input reaches
// the file combinationally.
module rf_ctrl #(
    parameter int unsigned BW    = 8,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,

    // Command interface
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [BW-1:0] cmd_imm,

    // Register file ports
    output logic          rf_chip_en,
    output logic [AW-1:0] rf_read_addr_1,
    output logic [AW-1:0] rf_read_addr_2,
    output logic [AW-1:0] rf_write_addr,
    output logic          rf_write_en_n,
    output logic [BW-1:0] rf_data_in,
    input  logic [BW-1:0] rf_data_out_1,
    input  logic [BW-1:0] rf_data_out_2,

    // Status
    output logic [BW-1:0] result,
    output logic          ovf,
    output logic          done
);

    localparam logic [2:0] OpNop = 3'd0;
    localparam logic [2:0] OpMov = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpSub = 3'd3;
    localparam logic [2:0] OpAnd = 3'd4;
    localparam logic [2:0] OpOr  = 3'd5;
    localparam logic [2:0] OpXor = 3'd6;
    localparam logic [2:0] OpLdi = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

    state_e        state_q, state_d;

    // Latched command fields
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;

    // Write-back value doubles as the visible result and the file's write data
    logic [BW-1:0] result_q, result_d;
    logic          ovf_q, ovf_d;
    logic          nop_done_q, nop_done_d;

    logic          handshake;
    logic          latch_dst;
    logic          latch_src;
    logic [BW-1:0] op_a, op_b;
    logic [BW-1:0] sum, diff;
    logic [BW-1:0] alu_res;
    logic          alu_ovf;

    assign handshake = cmd_valid & cmd_ready;

    // NOP touches nothing, so it must not disturb the held addresses
    assign latch_dst = handshake && (cmd_op != OpNop);
    // Only ALU ops carry source registers; LDI leaves the read addresses alone
    assign latch_src = handshake && (cmd_op != OpNop) && (cmd_op != OpLdi);

    // Operands arrive from the file one cycle after the READ cycle, i.e. during EXEC
    assign op_a = rf_data_out_1;
    assign op_b = rf_data_out_2;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Signed ALU; overflow is judged from the operand and result sign bits
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OpMov: alu_res = op_a;
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (op_a[BW-1] == op_b[BW-1]) && (sum[BW-1] != op_a[BW-1]);
            end
            OpSub: begin
                alu_res = diff;
                // A - B overflows like A + ~B: operands of opposite sign, result sign flips
                alu_ovf = (op_a[BW-1] != op_b[BW-1]) && (diff[BW-1] != op_a[BW-1]);
            end
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            default: alu_res = '0;
        endcase
    end

    // Next-state, result update and NOP completion
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        nop_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    case (cmd_op)
                        OpNop: nop_done_d = 1'b1;
                        OpLdi: begin
                            // Immediate goes straight to the write-back register
                            state_d  = StWrite;
                            result_d = cmd_imm;
                            ovf_d    = 1'b0;
                        end
                        default: state_d = StRead;
                    endcase
                end
            end
            StRead: state_d = StExec;
            StExec: begin
                state_d  = StWrite;
                result_d = alu_res;
                ovf_d    = alu_ovf;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, command latch and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpNop;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            nop_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            nop_done_q <= nop_done_d;
            if (latch_dst) begin
                op_q <= cmd_op;
                rd_q <= cmd_rd;
            end
            if (latch_src) begin
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
            end
        end
    end

    // Control outputs decoded from state; reset forces the file idle and refuses commands
    always_comb begin
        cmd_ready     = 1'b0;
        rf_chip_en    = 1'b0;
        rf_write_en_n = 1'b1;
        done          = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    cmd_ready = 1'b1;
                    done      = nop_done_q;
                end
                StRead, StExec: rf_chip_en = 1'b1;
                StWrite: begin
                    rf_chip_en    = 1'b1;
                    rf_write_en_n = 1'b0;
                    done          = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Addresses and write data come straight from registers, so they hold between commands
    assign rf_read_addr_1 = rs1_q;
    assign rf_read_addr_2 = rs2_q;
    assign rf_write_addr  = rd_q;
    assign rf_data_in     = result_q;
    assign result         = result_q;
    assign ovf            = ovf_q;

endmodule
